// File: rtl/pipe_ctrl.sv
// Pipeline control: turns per-stage stall requests and redirect pulses into
// hold/bubble/flush controls, with deferred flushes, event counters and a watchdog.
module pipe_ctrl #(
  parameter int STAGES    = 5,
  parameter int FLUSH_MIN = 4,
  parameter int CNT_W     = 32,
  parameter int WDOG      = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [STAGES-1:0] stall_req,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc,
  output logic [STAGES:0]   stall,
  output logic [STAGES-1:0] bubble,
  output logic              flush,
  output logic              npc_valid,
  output logic [31:0]       npc,
  output logic              busy_flush,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count,
  output logic              wdog_err
);

  // state | meaning
  // RUN   | normal operation, stall merge active
  // FLUSH | one-cycle redirect: flush + npc_valid, stall/bubble forced low
  // PEND  | redirect latched, waiting for late-stage stalls to drop
  typedef enum logic [1:0] {RUN, FLUSH, PEND} state_e;

  localparam int WD_W = $clog2(WDOG + 1);

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              replay_q, replay_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;

  logic [STAGES:0]   above;
  logic [STAGES:0]   merge_stall;
  logic [STAGES-1:0] merge_bubble;
  logic              blocked;
  logic              in_flush;

  // above[k]: some stage at 0-based index >= k is requesting
  always_comb begin
    above = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      above[k] = above[k+1] | stall_req[k];
    end
  end

  assign merge_stall[0] = above[0];
  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_merge
      assign merge_stall[g+1] = above[g];
      if (g < STAGES - 1) begin : g_bub
        assign merge_bubble[g] = stall_req[g] & ~above[g+1];
      end else begin : g_top
        assign merge_bubble[g] = 1'b0;
      end
    end
  endgenerate

  assign blocked  = |(stall_req >> (FLUSH_MIN - 1));
  assign in_flush = (state_q == FLUSH) && !reset;

  assign stall        = in_flush ? '0 : merge_stall;
  assign bubble       = in_flush ? '0 : merge_bubble;
  assign flush        = in_flush;
  assign npc_valid    = in_flush;
  assign npc          = pc_q;
  assign busy_flush   = (state_q == PEND) && !reset;
  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
  assign wdog_err     = err_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    replay_d = replay_q;
    unique case (state_q)
      RUN: begin
        if (flush_req || replay_q) begin
          if (flush_req) pc_d = flush_pc;
          replay_d = 1'b0;
          state_d  = blocked ? PEND : FLUSH;
        end
      end
      FLUSH: begin
        // a redirect landing on the flush cycle is replayed from RUN next cycle
        if (flush_req) begin
          pc_d     = flush_pc;
          replay_d = 1'b1;
        end
        state_d = RUN;
      end
      PEND: begin
        if (flush_req) pc_d = flush_pc;
        if (!blocked) state_d = FLUSH;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(|stall);
    flush_cnt_d = flush_cnt_q + CNT_W'(in_flush);
    wd_d        = wd_q;
    if (stall[0]) begin
      if (wd_q != WD_W'(WDOG)) wd_d = wd_q + 1'b1;
    end else begin
      wd_d = '0;
    end
    err_d = err_q | (wd_d == WD_W'(WDOG));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= '0;
      replay_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      replay_q    <= replay_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the MIPS core. It replaces the externally driven `stall[5:0]` vector with a generated one. It merges per-stage stall requests and a redirect/flush request into hold, bubble and flush controls for `STAGES` pipeline registers plus the PC. It also defers flushes that arrive while a late stage is stalled, counts stall and flush events, and flags a stuck pipeline with a watchdog.

## Interface
- `STAGES`, default 5: number of pipeline stages; stage 1 = IF … stage `STAGES` = WB.
- `FLUSH_MIN`, default 4: lowest stage whose stall blocks a flush (default: MEM).
- `CNT_W`, default 32: width of performance counters.
- `WDOG`, default 1024: consecutive stalled cycles before `wdog_err` sets.
- `clk` in 1: clock; all state updates on the rising edge. One clock; reset is synchronous, active-high.
- `reset` in 1: synchronous, active-high.
- `stall_req` in `STAGES`: bit s-1 = stage s requests a hold this cycle (level).
- `flush_req` in 1: one-cycle pulse requesting redirect.
- `flush_pc` in 32: redirect target, sampled with `flush_req`.
- `stall` out `STAGES+1`: bit 0 = hold PC; bit k = hold register after stage k. Same encoding as the existing `stall` bus.
- `bubble` out `STAGES`: bit k-1 = load NOP into register after stage k.
- `flush` out 1: clear every pipeline register.
- `npc_valid` out 1: load `npc` into PC, overriding `stall[0]`.
- `npc` out 32: redirect target.
- `busy_flush` out 1: a deferred flush is pending.
- `stall_cycles` out `CNT_W`: cycles with any `stall` bit set.
- `flush_count` out `CNT_W`: flushes issued.
- `wdog_err` out 1: sticky watchdog error.

## Operation
Stall merge is combinational from `stall_req`:
- s = highest requesting stage.
- `stall[s:0]` = 1; all other bits 0.
- `bubble[s-1]` = 1 if s < `STAGES`; all other bits 0.
- No request: `stall` = 0, `bubble` = 0.
- Example, `STAGES`=5, ID request: `stall` = 6'b000111, `bubble` = 5'b00010.

FSM states: RUN, FLUSH, PEND.

RUN:
- `flush_req` with no `stall_req` bit at index ≥ `FLUSH_MIN`-1: latch `flush_pc`, go to FLUSH.
- Otherwise on `flush_req`: latch `flush_pc`, go to PEND.

FLUSH (exactly 1 cycle):
- `flush` = 1, `npc_valid` = 1, `npc` = latched PC.
- `stall` and `bubble` forced to 0.
- `flush_count` += 1.
- Next state RUN.

PEND:
- `busy_flush` = 1; normal stall merge continues.
- Go to FLUSH in the first cycle where no blocking stall bit is set.

Flush request rules:
- A new `flush_req` in PEND overwrites the latched PC (newest wins); the count is still 1.
- A `flush_req` in FLUSH is latched and handled as if it arrived in RUN on the next cycle. Back-to-back flushes therefore issue on consecutive alternating cycles.

Counters:
- `stall_cycles` increments every cycle with `stall` ≠ 0, including PEND; it is not incremented in FLUSH.
- Both counters wrap modulo 2^`CNT_W`.

Watchdog:
- An internal counter counts consecutive cycles with `stall[0]` = 1; it clears on any cycle with `stall[0]` = 0.
- On reaching `WDOG`, `wdog_err` sets and stays set until reset.

## Timing
- Stall/bubble path is combinational, zero latency.
- `flush`/`npc_valid` assert 1 cycle after an unblocked `flush_req`, and 1 cycle after the blocking stall clears when deferred.
- Reset values:
  - state RUN;
  - `flush`, `npc_valid`, `busy_flush`, `wdog_err` = 0;
  - `npc` = 0;
  - counters = 0;
  - watchdog counter = 0.
- While `reset` is asserted, `stall`/`bubble` still follow `stall_req`.
- Reset mid-PEND or mid-FLUSH discards the pending redirect; no flush is issued afterwards.
- `flush_req` in the same cycle as `reset` is ignored.

## Test plan
- ID stall (`stall_req`=5'b00010) for 3 cycles → `stall`=6'b000111 and `bubble`=5'b00010 each cycle; `stall_cycles`=3.
- Simultaneous IF+EXE requests (5'b00101) → `stall`=6'b001111, `bubble`=5'b00100.
- `flush_req`, `flush_pc`=0xBFC0_0380, no stalls → next cycle `flush`=`npc_valid`=1, `npc`=0xBFC0_0380, `stall`=0; `flush_count`=1.
- Deferred flush: MEM stall held 4 cycles, `flush_req` in its 1st cycle (pc 0x100), second `flush_req` in its 3rd cycle (pc 0x200) → `busy_flush` high for the stall window; single flush with `npc`=0x200 in the cycle after MEM stall drops; `flush_count`=1.
- Reset during PEND → no flush after reset; all outputs and counters at reset values.
- `WDOG`=8, IF stall held 10 cycles → `wdog_err` rises after 8 stalled cycles and stays 1 after stall release.
